ex_div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage; it produces the 64-bit `{remainder, quotient}` value that EX forwards downstream as `div_result`, with `div_flag` set. It computes one quotient bit per cycle (restoring division). While busy it requests an EX stall. It is started by DIV/DIVU decode in EX and supports both signed and unsigned operands.

---
 rtl/ex_div_unit_pkg.sv | 16 +
 rtl/ex_div_unit_step.sv | 28 ++
 rtl/ex_div_unit.sv | 165 ++++++++++++++++
 tb/tb_ex_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: FSM state encodings,
// result bus width and the start/stop levels of the EX start request.
package ex_div_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_DIVZERO = 2'b01,
        S_ON      = 2'b10,
        S_END     = 2'b11
    } div_state_e;

    localparam int   DIV_RESULT_BUS_W = 64;
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;

endpackage

// File: rtl/ex_div_unit_step.sv
// One restoring-division step: shift the partial remainder left, bring in the
// next dividend bit, and subtract the divisor when it fits.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] shifted;

    // The incoming remainder is always below the divisor, so the restored
    // value fits back into WIDTH bits and the subtraction may wrap freely.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        if (shifted >= {1'b0, divisor_i}) begin
            rem_o      = shifted[WIDTH-1:0] - divisor_i;
            quot_bit_o = 1'b1;
        end else begin
            rem_o      = shifted[WIDTH-1:0];
            quot_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// EX-stage multi-cycle divider (restoring, one quotient bit per cycle).
// Produces {remainder, quotient}; requests an EX stall while working.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               stall_req_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;       // |dividend|, shifted out MSB first
    logic [WIDTH-1:0]   dvs_q, dvs_d;       // |divisor|
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;       // quotient bits collected so far
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   quo_next;
    logic               op1_neg;
    logic               op2_neg;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .dvd_bit_i  (dvd_q[WIDTH-1]),
        .divisor_i  (dvs_q),
        .rem_o      (step_rem),
        .quot_bit_o (step_qbit)
    );

    assign quo_next = {quo_q[WIDTH-2:0], step_qbit};
    assign op1_neg  = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg  = signed_i & opdata2_i[WIDTH-1];

    // Next-state, datapath and registered-output logic; annul overrides all.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;

        if (annul_i) begin
            state_d    = S_IDLE;
            count_d    = '0;
            result_d   = '0;
            ready_d    = 1'b0;
            div_zero_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i == DIV_START) begin
                        // Two's-complement negation maps the most negative
                        // value onto itself, which is its correct magnitude.
                        dvd_d     = op1_neg ? -opdata1_i : opdata1_i;
                        dvs_d     = op2_neg ? -opdata2_i : opdata2_i;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                        rem_d     = '0;
                        quo_d     = '0;
                        count_d   = '0;
                        state_d   = (opdata2_i == '0) ? S_DIVZERO : S_ON;
                    end
                end
                S_DIVZERO: begin
                    state_d    = S_END;
                    result_d   = '0;
                    ready_d    = 1'b1;
                    div_zero_d = 1'b1;
                end
                S_ON: begin
                    rem_d   = step_rem;
                    quo_d   = quo_next;
                    dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        state_d    = S_END;
                        count_d    = '0;
                        ready_d    = 1'b1;
                        div_zero_d = 1'b0;
                        result_d   = {(neg_rem_q ? -step_rem : step_rem),
                                      (neg_quo_q ? -quo_next : quo_next)};
                    end
                end
                S_END: begin
                    if (start_i == DIV_STOP) begin
                        state_d    = S_IDLE;
                        result_d   = '0;
                        ready_d    = 1'b0;
                        div_zero_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Stall EX from the accepting cycle until the result is ready.
    always_comb begin
        stall_req_o = ((state_q == S_IDLE) & start_i & ~annul_i)
                    | (state_q == S_DIVZERO)
                    | (state_q == S_ON);
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed testbench for ex_div_unit.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        div_zero_o;
    logic        stall_req_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .div_zero_o  (div_zero_o),
        .stall_req_o (stall_req_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Raise start with the given operands and wait (bounded) for ready_o.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_edges,
                           input logic [63:0] exp_res, input logic exp_dz);
        int cnt;
        cnt       = 0;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        #1;
        check({tag, "_stall_accept"}, 64'(stall_req_o), 64'd1);
        while (!ready_o && cnt < 100) begin
            edge1();
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(exp_edges));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_div_zero"}, 64'(div_zero_o), 64'(exp_dz));
        check({tag, "_stall_ready"}, 64'(stall_req_o), 64'd0);
    endtask

    // Drop start and confirm the unit returns to IDLE with cleared outputs.
    task automatic finish_div(input string tag);
        start_i = 1'b0;
        edge1();
        check({tag, "_ready_clr"}, 64'(ready_o), 64'd0);
        check({tag, "_result_clr"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        logic [63:0] held;
        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        #12;
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_div_zero", 64'(div_zero_o), 64'd0);
        check("rst_stall", 64'(stall_req_o), 64'd0);
        rst = 1'b1;
        edge1();

        run_div("udiv_7_2", 1'b0, 32'd7, 32'd2, 33, {32'd1, 32'd3}, 1'b0);
        finish_div("udiv_7_2");
        run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        finish_div("sdiv_m7_2");
        run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        finish_div("sdiv_7_m2");
        run_div("udiv_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'd1, 32'h7FFF_FFFC}, 1'b0);
        finish_div("udiv_m7_2");
        run_div("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, 1'b0);
        finish_div("sdiv_min_m1");
        run_div("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        finish_div("udiv_max_1");
        run_div("div_zero", 1'b0, 32'd1234, 32'd0, 2, 64'd0, 1'b1);
        finish_div("div_zero");

        // Hold start high in END for 5 cycles: result stable, no restart.
        run_div("hold", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333}, 1'b0);
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            edge1();
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, held);
            check("hold_stall", 64'(stall_req_o), 64'd0);
        end
        finish_div("hold");

        // Annul beats start in IDLE.
        annul_i  = 1'b1;
        start_i  = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        #1;
        check("annul_idle_stall", 64'(stall_req_o), 64'd0);
        edge1();
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("annul_idle_stall_after", 64'(stall_req_o), 64'd0);
        edge1();

        // Annul during the 10th step.
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (10) edge1();
        check("annul_on_stall", 64'(stall_req_o), 64'd1);
        annul_i = 1'b1;
        start_i = 1'b0;
        edge1();
        annul_i = 1'b0;
        #1;
        check("annul_to_idle_stall", 64'(stall_req_o), 64'd0);
        seen = 0;
        repeat (40) begin
            edge1();
            if (ready_o) seen = 1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div("after_annul", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);
        finish_div("after_annul");

        // Asynchronous reset at step 20.
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (20) edge1();
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("mid_rst_result", result_o, 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd0);
        check("mid_rst_stall", 64'(stall_req_o), 64'd0);
        edge1();
        rst = 1'b1;
        edge1();
        check("post_rst_ready", 64'(ready_o), 64'd0);
        run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);
        finish_div("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
